// File: rtl/spi_slave_axi_pkg.sv
// Shared types and constants for the SPI-slave-driven AXI4-Lite master.
package spi_slave_axi_pkg;

  typedef enum logic [1:0] {
    W_IDLE,
    W_REQ,
    W_RESP
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ADDR,
    R_DATA
  } r_state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/spi_axi_txn_timer.sv
// Busy-cycle counter for one AXI channel; expired fires on the last allowed busy cycle.
module spi_axi_txn_timer
  import spi_slave_axi_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic core_clk,
  input  logic core_reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [4:0] count;

  always_ff @(posedge core_clk or negedge core_reset_n) begin
    if (!core_reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 5'd1;
    end
  end

  // Combinational so the owning FSM aborts on the same edge the count would reach the limit.
  assign expired = enable && (count == 5'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/spi_slave_axi_master_lite.sv
// AXI4-Lite master with independent single-beat write and read engines started by user pulses.
module spi_slave_axi_master_lite
  import spi_slave_axi_pkg::*;
#(
  parameter int unsigned SPI_ADDR_WIDTH = 20,
  parameter logic [31:0] AXI_BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                      core_clk,
  input  logic                      core_reset_n,
  input  logic                      init_w_axi_txn,
  input  logic                      init_r_axi_txn,
  input  logic [SPI_ADDR_WIDTH-1:0] user_awaddr,
  input  logic [SPI_ADDR_WIDTH-1:0] user_araddr,
  input  logic [31:0]               user_wdata,
  output logic [31:0]               user_rdata,
  output logic                      done_w_axi_txn,
  output logic                      done_r_axi_txn,
  output logic                      error_w_axi_txn,
  output logic                      error_r_axi_txn,
  output logic [31:0]               m_axi_awaddr,
  output logic [2:0]                m_axi_awprot,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [31:0]               m_axi_wdata,
  output logic [3:0]                m_axi_wstrb,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  input  logic [1:0]                m_axi_bresp,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready,
  output logic [31:0]               m_axi_araddr,
  output logic [2:0]                m_axi_arprot,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [31:0]               m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready
);

  w_state_t w_state;
  r_state_t r_state;
  logic     w_expired;
  logic     r_expired;
  logic     unused_resp_lsb;

  assign m_axi_wstrb     = 4'hF;
  assign m_axi_awprot    = 3'b000;
  assign m_axi_arprot    = 3'b000;
  assign unused_resp_lsb = m_axi_bresp[0] ^ m_axi_rresp[0];

  spi_axi_txn_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_w_timer (
    .core_clk     (core_clk),
    .core_reset_n (core_reset_n),
    .clear        (w_state == W_IDLE),
    .enable       (w_state != W_IDLE),
    .expired      (w_expired)
  );

  spi_axi_txn_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_r_timer (
    .core_clk     (core_clk),
    .core_reset_n (core_reset_n),
    .clear        (r_state == R_IDLE),
    .enable       (r_state != R_IDLE),
    .expired      (r_expired)
  );

  always_ff @(posedge core_clk or negedge core_reset_n) begin
    if (!core_reset_n) begin
      w_state         <= W_IDLE;
      m_axi_awaddr    <= '0;
      m_axi_wdata     <= '0;
      m_axi_awvalid   <= 1'b0;
      m_axi_wvalid    <= 1'b0;
      m_axi_bready    <= 1'b0;
      done_w_axi_txn  <= 1'b0;
      error_w_axi_txn <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (init_w_axi_txn) begin
            m_axi_awaddr    <= AXI_BASE_ADDR + 32'(user_awaddr);
            m_axi_wdata     <= user_wdata;
            done_w_axi_txn  <= 1'b0;
            error_w_axi_txn <= 1'b0;
            m_axi_awvalid   <= 1'b1;
            m_axi_wvalid    <= 1'b1;
            w_state         <= W_REQ;
          end
        end
        W_REQ: begin
          if (w_expired) begin
            m_axi_awvalid   <= 1'b0;
            m_axi_wvalid    <= 1'b0;
            done_w_axi_txn  <= 1'b1;
            error_w_axi_txn <= 1'b1;
            w_state         <= W_IDLE;
          end else begin
            if (m_axi_awready) m_axi_awvalid <= 1'b0;
            if (m_axi_wready)  m_axi_wvalid  <= 1'b0;
            // Each channel counts as accepted if it already handshook or does so now.
            if ((!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready)) begin
              m_axi_bready <= 1'b1;
              w_state      <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (w_expired) begin
            m_axi_bready    <= 1'b0;
            done_w_axi_txn  <= 1'b1;
            error_w_axi_txn <= 1'b1;
            w_state         <= W_IDLE;
          end else if (m_axi_bvalid) begin
            m_axi_bready    <= 1'b0;
            done_w_axi_txn  <= 1'b1;
            error_w_axi_txn <= m_axi_bresp[1];
            w_state         <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge core_clk or negedge core_reset_n) begin
    if (!core_reset_n) begin
      r_state         <= R_IDLE;
      m_axi_araddr    <= '0;
      m_axi_arvalid   <= 1'b0;
      m_axi_rready    <= 1'b0;
      user_rdata      <= '0;
      done_r_axi_txn  <= 1'b0;
      error_r_axi_txn <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (init_r_axi_txn) begin
            m_axi_araddr    <= AXI_BASE_ADDR + 32'(user_araddr);
            done_r_axi_txn  <= 1'b0;
            error_r_axi_txn <= 1'b0;
            m_axi_arvalid   <= 1'b1;
            r_state         <= R_ADDR;
          end
        end
        R_ADDR: begin
          if (r_expired) begin
            m_axi_arvalid   <= 1'b0;
            done_r_axi_txn  <= 1'b1;
            error_r_axi_txn <= 1'b1;
            r_state         <= R_IDLE;
          end else if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            r_state       <= R_DATA;
          end
        end
        R_DATA: begin
          if (r_expired) begin
            m_axi_rready    <= 1'b0;
            done_r_axi_txn  <= 1'b1;
            error_r_axi_txn <= 1'b1;
            r_state         <= R_IDLE;
          end else if (m_axi_rvalid) begin
            user_rdata      <= m_axi_rdata;
            m_axi_rready    <= 1'b0;
            done_r_axi_txn  <= 1'b1;
            error_r_axi_txn <= m_axi_rresp[1];
            r_state         <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_axi_master_lite.sv
// Directed plus randomized bench with a simple responding AXI slave and a flag/latency reference model.
module tb_spi_slave_axi_master_lite;

  localparam logic [31:0] BASE = 32'hFFFF_F000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        init_w, init_r;
  logic [19:0] awaddr_in, araddr_in;
  logic [31:0] wdata_in;
  logic [31:0] user_rdata;
  logic        done_w, done_r, err_w, err_r;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [2:0]  m_awprot, m_arprot;
  logic [3:0]  m_wstrb;
  logic        m_awvalid, m_awready, m_wvalid, m_wready;
  logic [1:0]  m_bresp, m_rresp;
  logic        m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;
  logic        b_en, r_en;

  int total = 0;
  int bad   = 0;

  // Model state: flags and read data as the master should be presenting them.
  logic        exp_done_w, exp_err_w, exp_done_r, exp_err_r;
  logic [31:0] exp_rdata;

  always #5 clk = ~clk;

  // Slave answers B/R in the same cycle the master becomes ready, when enabled.
  assign m_bvalid = m_bready & b_en;
  assign m_rvalid = m_rready & r_en;

  spi_slave_axi_master_lite #(
    .SPI_ADDR_WIDTH (20),
    .AXI_BASE_ADDR  (BASE),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .core_clk        (clk),
    .core_reset_n    (rst_n),
    .init_w_axi_txn  (init_w),
    .init_r_axi_txn  (init_r),
    .user_awaddr     (awaddr_in),
    .user_araddr     (araddr_in),
    .user_wdata      (wdata_in),
    .user_rdata      (user_rdata),
    .done_w_axi_txn  (done_w),
    .done_r_axi_txn  (done_r),
    .error_w_axi_txn (err_w),
    .error_r_axi_txn (err_r),
    .m_axi_awaddr    (m_awaddr),
    .m_axi_awprot    (m_awprot),
    .m_axi_awvalid   (m_awvalid),
    .m_axi_awready   (m_awready),
    .m_axi_wdata     (m_wdata),
    .m_axi_wstrb     (m_wstrb),
    .m_axi_wvalid    (m_wvalid),
    .m_axi_wready    (m_wready),
    .m_axi_bresp     (m_bresp),
    .m_axi_bvalid    (m_bvalid),
    .m_axi_bready    (m_bready),
    .m_axi_araddr    (m_araddr),
    .m_axi_arprot    (m_arprot),
    .m_axi_arvalid   (m_arvalid),
    .m_axi_arready   (m_arready),
    .m_axi_rdata     (m_rdata),
    .m_axi_rresp     (m_rresp),
    .m_axi_rvalid    (m_rvalid),
    .m_axi_rready    (m_rready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk_flags(input string tag);
    chk({tag, ".done_w"}, 32'(done_w), 32'(exp_done_w));
    chk({tag, ".err_w"},  32'(err_w),  32'(exp_err_w));
    chk({tag, ".done_r"}, 32'(done_r), 32'(exp_done_r));
    chk({tag, ".err_r"},  32'(err_r),  32'(exp_err_r));
    chk({tag, ".rdata"},  user_rdata,  exp_rdata);
  endtask

  // One transaction on either or both channels with readys high; checks every cycle N+1..N+3.
  task automatic txn(input bit dw, input bit dr, input logic [19:0] wa, input logic [31:0] wd,
                     input logic [1:0] br, input logic [19:0] ra, input logic [31:0] rd,
                     input logic [1:0] rr, input bit second_w);
    logic [31:0] ea_w, ea_r;
    ea_w = BASE + {12'h000, wa};
    ea_r = BASE + {12'h000, ra};
    init_w = dw; init_r = dr;
    awaddr_in = wa; wdata_in = wd; araddr_in = ra;
    m_bresp = br; m_rdata = rd; m_rresp = rr;
    @(negedge clk);
    init_w = 1'b0; init_r = 1'b0;
    if (dw) begin
      exp_done_w = 1'b0; exp_err_w = 1'b0;
      chk("n1.awvalid", 32'(m_awvalid), 32'd1);
      chk("n1.wvalid",  32'(m_wvalid),  32'd1);
      chk("n1.awaddr",  m_awaddr, ea_w);
      chk("n1.wdata",   m_wdata,  wd);
      chk("n1.wstrb",   32'(m_wstrb), 32'hF);
    end
    if (dr) begin
      exp_done_r = 1'b0; exp_err_r = 1'b0;
      chk("n1.arvalid", 32'(m_arvalid), 32'd1);
      chk("n1.araddr",  m_araddr, ea_r);
    end
    chk_flags("n1");
    @(negedge clk);
    if (dw) begin
      chk("n2.awvalid", 32'(m_awvalid), 32'd0);
      chk("n2.wvalid",  32'(m_wvalid),  32'd0);
      chk("n2.bready",  32'(m_bready),  32'd1);
    end
    if (dr) begin
      chk("n2.arvalid", 32'(m_arvalid), 32'd0);
      chk("n2.rready",  32'(m_rready),  32'd1);
    end
    chk_flags("n2");
    if (second_w) begin
      init_w = 1'b1; awaddr_in = ~wa; wdata_in = ~wd;
    end
    @(negedge clk);
    init_w = 1'b0;
    if (dw) begin exp_done_w = 1'b1; exp_err_w = br[1]; end
    if (dr) begin exp_done_r = 1'b1; exp_err_r = rr[1]; exp_rdata = rd; end
    chk_flags("n3");
    chk("n3.awvalid", 32'(m_awvalid), 32'd0);
    chk("n3.bready",  32'(m_bready),  32'd0);
    chk("n3.arvalid", 32'(m_arvalid), 32'd0);
    chk("n3.rready",  32'(m_rready),  32'd0);
    if (second_w) begin
      @(negedge clk);
      chk("ign.awvalid", 32'(m_awvalid), 32'd0);
      chk("ign.wvalid",  32'(m_wvalid),  32'd0);
      chk_flags("ign");
    end
  endtask

  initial begin
    rst_n = 1'b0; init_w = 1'b0; init_r = 1'b0;
    awaddr_in = '0; araddr_in = '0; wdata_in = '0;
    m_awready = 1'b1; m_wready = 1'b1; m_arready = 1'b1;
    m_bresp = '0; m_rresp = '0; m_rdata = '0; b_en = 1'b1; r_en = 1'b1;
    exp_done_w = 1'b0; exp_err_w = 1'b0; exp_done_r = 1'b0; exp_err_r = 1'b0; exp_rdata = '0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst.awvalid", 32'(m_awvalid), 32'd0);
    chk("rst.wvalid",  32'(m_wvalid),  32'd0);
    chk("rst.bready",  32'(m_bready),  32'd0);
    chk("rst.arvalid", 32'(m_arvalid), 32'd0);
    chk("rst.rready",  32'(m_rready),  32'd0);
    chk("rst.awaddr",  m_awaddr, 32'd0);
    chk("rst.araddr",  m_araddr, 32'd0);
    chk("rst.wdata",   m_wdata,  32'd0);
    chk("rst.prot",    32'({m_awprot, m_arprot}), 32'd0);
    chk_flags("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Write wrapping past 2^32, OKAY, then read at top of user range
    txn(1'b1, 1'b0, 20'h01010, 32'hDEADBEEF, AXI_RESP_OKAY(), 20'h0, 32'h0, 2'b00, 1'b0);
    chk("wrap.addr", m_awaddr, 32'h0000_0010);
    txn(1'b0, 1'b1, 20'h0, 32'h0, 2'b00, 20'hFFFFF, 32'h12345678, 2'b00, 1'b0);
    chk("rd.addr", m_araddr, 32'h000F_EFFF);

    // wready accepted three cycles ahead of awready, SLVERR
    m_awready = 1'b0; m_bresp = 2'b10;
    awaddr_in = 20'h00020; wdata_in = 32'hCAFEF00D; init_w = 1'b1;
    @(negedge clk);
    init_w = 1'b0; exp_done_w = 1'b0; exp_err_w = 1'b0;
    chk("ooo.wvalid1", 32'(m_wvalid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ooo.wvalid",  32'(m_wvalid),  32'd0);
      chk("ooo.awvalid", 32'(m_awvalid), 32'd1);
      chk("ooo.awaddr",  m_awaddr, 32'h0000_0020 + BASE);
      chk("ooo.bready",  32'(m_bready),  32'd0);
      chk("ooo.done",    32'(done_w),    32'd0);
    end
    m_awready = 1'b1;
    @(negedge clk);
    chk("ooo.awvalid0", 32'(m_awvalid), 32'd0);
    chk("ooo.bready1",  32'(m_bready),  32'd1);
    @(negedge clk);
    exp_done_w = 1'b1; exp_err_w = 1'b1;
    chk_flags("ooo");

    // Read with arready stuck low times out after 16 busy cycles
    m_arready = 1'b0; araddr_in = 20'h00444; init_r = 1'b1;
    @(negedge clk);
    init_r = 1'b0; exp_done_r = 1'b0; exp_err_r = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("to.arvalid", 32'(m_arvalid), 32'd1);
      chk("to.done_r",  32'(done_r),    32'd0);
      @(negedge clk);
    end
    exp_done_r = 1'b1; exp_err_r = 1'b1;
    chk("to.arvalid0", 32'(m_arvalid), 32'd0);
    chk("to.rready",   32'(m_rready),  32'd0);
    chk_flags("to");
    m_arready = 1'b1;

    // Simultaneous starts, second write start ignored while busy
    txn(1'b1, 1'b1, 20'h00ABC, 32'h0BADF00D, 2'b11, 20'h00DEF, 32'hA5A5_5A5A, 2'b01, 1'b1);

    // Reset during W_RESP abandons the write asynchronously
    b_en = 1'b0; awaddr_in = 20'h00100; wdata_in = 32'h1111_2222; init_w = 1'b1;
    @(negedge clk);
    init_w = 1'b0;
    @(negedge clk);
    chk("mr.bready", 32'(m_bready), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr.bready0",  32'(m_bready),  32'd0);
    chk("mr.awvalid0", 32'(m_awvalid), 32'd0);
    chk("mr.awaddr0",  m_awaddr, 32'd0);
    exp_done_w = 1'b0; exp_err_w = 1'b0; exp_done_r = 1'b0; exp_err_r = 1'b0; exp_rdata = '0;
    chk_flags("mr");
    @(negedge clk);
    rst_n = 1'b1; b_en = 1'b1;
    @(negedge clk);
    chk_flags("mr.post");
    txn(1'b1, 1'b0, 20'h00200, 32'h3333_4444, 2'b00, 20'h0, 32'h0, 2'b00, 1'b0);

    // Randomized traffic against the model
    for (int n = 0; n < 24; n++) begin
      bit dw, dr;
      dw = 1'($urandom_range(0, 1));
      dr = 1'($urandom_range(0, 1));
      if (!dw && !dr) dr = 1'b1;
      txn(dw, dr, 20'($urandom), $urandom, 2'($urandom), 20'($urandom), $urandom,
          2'($urandom), 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      chk_flags("rnd.hold");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  function automatic logic [1:0] AXI_RESP_OKAY();
    return 2'b00;
  endfunction

endmodule

// File: doc/spi_slave_axi_master_lite.md
SPI_SLAVE_AXI_MASTER_LITE -- requirements
Module: spi_slave_axi_master_lite

Interface
REQ-001 SPI_ADDR_WIDTH, default 20, width of the user address inputs.
REQ-002 AXI_BASE_ADDR, default 32'h0000_0000, added to each user address to form the 32-bit AXI address.
REQ-003 TIMEOUT_CYCLES, default 16, range 2..31, cycles a channel may stay busy before it aborts.
REQ-004 core_clk  in  1  single clock for all logic.
REQ-005 core_reset_n  in  1  asynchronous, active-low reset.
REQ-006 init_w_axi_txn  in  1  one-cycle write-start pulse.
REQ-007 init_r_axi_txn  in  1  one-cycle read-start pulse.
REQ-008 user_awaddr  in  SPI_ADDR_WIDTH  write address, sampled with init_w_axi_txn.
REQ-009 user_araddr  in  SPI_ADDR_WIDTH  read address, sampled with init_r_axi_txn.
REQ-010 user_wdata  in  32  write data, sampled with init_w_axi_txn.
REQ-011 user_rdata  out  32  data from the last completed read.
REQ-012 done_w_axi_txn / done_r_axi_txn  out  1 each  level completion flags.
REQ-013 error_w_axi_txn / error_r_axi_txn  out  1 each  level error flags.
REQ-014 m_axi_awaddr out 32, m_axi_awprot out 3, m_axi_awvalid out 1, m_axi_awready in 1  AW channel.
REQ-015 m_axi_wdata out 32, m_axi_wstrb out 4, m_axi_wvalid out 1, m_axi_wready in 1  W channel.
REQ-016 m_axi_bresp in 2, m_axi_bvalid in 1, m_axi_bready out 1  B channel.
REQ-017 m_axi_araddr out 32, m_axi_arprot out 3, m_axi_arvalid out 1, m_axi_arready in 1  AR channel.
REQ-018 m_axi_rdata in 32, m_axi_rresp in 2, m_axi_rvalid in 1, m_axi_rready out 1  R channel.

Function
REQ-019 The write FSM and read FSM SHALL be independent and SHALL both accept when their pulses arrive in the same cycle.
REQ-020 Write FSM states SHALL be W_IDLE, W_REQ and W_RESP.
REQ-021 In W_IDLE, init_w SHALL latch address = AXI_BASE_ADDR + zero-extended user_awaddr (mod 2^32) and latch user_wdata.
REQ-022 On that same edge, the write FSM SHALL clear done_w and error_w, assert awvalid and wvalid, and enter W_REQ.
REQ-023 awvalid and wvalid SHALL each drop the cycle after their own ready handshake; W_RESP SHALL be entered once both have been accepted, in either order or the same cycle.
REQ-024 In W_RESP, bready SHALL be 1; on bvalid, the FSM SHALL set done_w=1, set error_w=bresp[1], drop bready and return to W_IDLE.
REQ-025 Read FSM states SHALL be R_IDLE, R_ADDR and R_DATA.
REQ-026 init_r SHALL latch the address, clear done_r and error_r, and assert arvalid; arready SHALL move the FSM to R_DATA with rready=1.
REQ-027 On rvalid in R_DATA: user_rdata<=rdata, done_r=1, error_r=rresp[1], return to R_IDLE.
REQ-028 Latency with all readys tied high SHALL be: init at cycle N, valid at N+1, done visible at N+3.
REQ-029 done and error flags SHALL hold until the next accepted init on the same channel; user_rdata SHALL hold until the next read completes.
REQ-030 init pulses received while a channel is not idle SHALL be ignored, with no state change.
REQ-031 Address and data outputs SHALL be stable while the corresponding valid is high, and no valid SHALL drop before its ready except on timeout.
REQ-032 m_axi_wstrb SHALL be 4'hF, and awprot and arprot SHALL be 3'b000.
REQ-033 A per-channel counter SHALL count busy cycles; when it reaches TIMEOUT_CYCLES, that channel SHALL drop all valid and ready outputs, set done=1 and error=1, and return to idle.
REQ-034 TIMEOUT_CYCLES SHALL be less than 32 so the upstream sequencer (32-cycle timeout) always observes completion.

Reset
REQ-035 On core_reset_n low, both FSMs SHALL go idle and all outputs, flags, user_rdata and counters SHALL be 0.
REQ-036 Reset mid-transaction SHALL abandon the transaction at once, with valids deasserted asynchronously and no done reported.

Structure
REQ-037 Package spi_slave_axi_pkg SHALL hold the write and read state enums, AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR, and the default TIMEOUT_CYCLES.
REQ-038 The busy counter SHALL be one sub-module, spi_axi_txn_timer (clear, enable, expired), instantiated once per channel.

Verification
REQ-039 Write, BASE 32'h4000_0000, awaddr 20'h00010, wdata 32'hDEADBEEF, readys high, bresp OKAY -> awaddr 32'h4000_0010, wstrb F, done_w at N+3, error_w 0.
REQ-040 Write with wready asserted 3 cycles before awready, bresp SLVERR -> wvalid drops first, awaddr stable, bready only after both accepted, error_w=1.
REQ-041 Read, BASE 32'hFFFF_F000, araddr 20'hFFFFF, rdata 32'h12345678, rresp OKAY -> araddr 32'h000F_EFFF, user_rdata 32'h12345678, done_r=1.
REQ-042 Read with arready held 0 -> arvalid high 16 cycles, then arvalid 0, done_r=1, error_r=1.
REQ-043 init_w and init_r in the same cycle, plus a second init_w two cycles later -> both complete, second init_w ignored, flags correct.
REQ-044 core_reset_n pulsed low during W_RESP -> all outputs 0 immediately; a later write completes normally.
